iir_axil_regbank: RTL and testbench

AXI4-Lite responder (slave) that holds the IIR filter's control and coefficient registers. It is the target the AXI4-Lite master BFM drives in block-level benches.
- Four read/write registers at offsets 0x00–0x0C, one read-only status register at 0x10; all other offsets are unmapped.
- Outputs the registers to the filter datapath and generates a one-cycle coefficient-update strobe.

---
 rtl/iir_axil_regbank.sv | 172 +++++++++++++++++
 tb/tb_iir_axil_regbank.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_axil_regbank.sv
// AXI4-Lite register bank for the IIR filter: CTRL and three coefficient registers,
// a sampled read-only STATUS word, and a one-cycle coefficient-update strobe.
module iir_axil_regbank #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   coef_b0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   coef_b1,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   coef_a1,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   status_in,
    output logic                            coef_update
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [3:0][31:0] regs_q, regs_d;
    logic [31:0]      status_q;
    logic             aw_full_q, aw_full_d;
    logic [2:0]       aw_idx_q, aw_idx_d;
    logic             w_full_q, w_full_d;
    logic [31:0]      w_data_q, w_data_d;
    logic [3:0]       w_strb_q, w_strb_d;
    logic             awready_q, awready_d;
    logic             wready_q, wready_d;
    logic             bvalid_q, bvalid_d;
    logic [1:0]       bresp_q, bresp_d;
    logic             coef_upd_q, coef_upd_d;
    logic             arready_q, arready_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       rresp_q, rresp_d;
    logic             commit;

    wire unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        regs_d     = regs_q;
        aw_full_d  = aw_full_q;
        aw_idx_d   = aw_idx_q;
        w_full_d   = w_full_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        coef_upd_d = 1'b0;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        commit     = aw_full_q && w_full_q;

        if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
        if (S_AXI_AWVALID && awready_q) begin
            aw_full_d = 1'b1;
            aw_idx_d  = S_AXI_AWADDR[4:2];
        end
        if (S_AXI_WVALID && wready_q) begin
            w_full_d = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
        end

        // Both halves latched: apply the write and raise the response together.
        if (commit) begin
            aw_full_d  = 1'b0;
            w_full_d   = 1'b0;
            bvalid_d   = 1'b1;
            bresp_d    = (aw_idx_q > 3'd4) ? RESP_SLVERR : RESP_OKAY;
            coef_upd_d = (aw_idx_q == 3'd0) && w_strb_q[0] && w_data_q[0];
            if (aw_idx_q < 3'd4) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_strb_q[b]) regs_d[aw_idx_q[1:0]][8*b +: 8] = w_data_q[8*b +: 8];
                end
            end
        end

        awready_d = !aw_full_d && !bvalid_d;
        wready_d  = !w_full_d && !bvalid_d;

        if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
        // Read samples the current (pre-commit) register contents.
        if (S_AXI_ARVALID && arready_q) begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_OKAY;
            case (S_AXI_ARADDR[4:2])
                3'd0, 3'd1, 3'd2, 3'd3: rdata_d = regs_q[S_AXI_ARADDR[3:2]];
                3'd4:                   rdata_d = status_q;
                default: begin
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                end
            endcase
        end
        arready_d = !rvalid_d;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            regs_q     <= '0;
            status_q   <= '0;
            aw_full_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            coef_upd_q <= 1'b0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            regs_q     <= regs_d;
            status_q   <= status_in;
            aw_full_q  <= aw_full_d;
            aw_idx_q   <= aw_idx_d;
            w_full_q   <= w_full_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            coef_upd_q <= coef_upd_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign ctrl          = regs_q[0];
    assign coef_b0       = regs_q[1];
    assign coef_b1       = regs_q[2];
    assign coef_a1       = regs_q[3];
    assign coef_update   = coef_upd_q;

endmodule

// File: tb/tb_iir_axil_regbank.sv
// Bench for iir_axil_regbank: directed scenarios plus random traffic against an
// array-based register model; inputs change and outputs are sampled on the falling edge.
module tb_iir_axil_regbank;
    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [4:0]  S_AXI_AWADDR, S_AXI_ARADDR;
    logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
    logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
    logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic        S_AXI_RVALID, S_AXI_RREADY;
    logic [31:0] ctrl, coef_b0, coef_b1, coef_a1, status_in;
    logic        coef_update;

    iir_axil_regbank #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .ctrl(ctrl), .coef_b0(coef_b0), .coef_b1(coef_b1), .coef_a1(coef_a1),
        .status_in(status_in), .coef_update(coef_update)
    );

    always #5 ACLK = ~ACLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain register array plus the value driven on status_in.
    logic [31:0] m_reg [4];
    logic [31:0] status_val;

    // Strobe monitor: a legal pulse is one cycle wide and lands on the first BVALID cycle.
    int   pulse_cnt = 0;
    int   pulse_bad = 0;
    logic prev_pulse = 1'b0;
    logic prev_bvalid = 1'b0;
    always @(negedge ACLK) begin
        if (coef_update === 1'b1) begin
            pulse_cnt++;
            if (prev_pulse || S_AXI_BVALID !== 1'b1 || prev_bvalid) pulse_bad++;
        end
        prev_pulse  = (coef_update === 1'b1);
        prev_bvalid = (S_AXI_BVALID === 1'b1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_bresp(input logic [4:0] addr);
        return (addr[4:2] > 3'd4) ? 2'b10 : 2'b00;
    endfunction

    task automatic model_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx = int'(addr[4:2]);
        if (idx < 4) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) m_reg[idx][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    task automatic model_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int idx = int'(addr[4:2]);
        resp = 2'b00;
        if (idx < 4)       data = m_reg[idx];
        else if (idx == 4) data = status_val;
        else begin
            data = 32'h0;
            resp = 2'b10;
        end
    endtask

    task automatic write_issue(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               input int aw_dly, input int w_dly);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_hs, w_hs;
        int cyc;
        S_AXI_AWADDR = addr;
        S_AXI_WDATA  = data;
        S_AXI_WSTRB  = strb;
        S_AXI_BREADY = 1'b0;
        for (cyc = 0; cyc < 64 && !(aw_done && w_done); cyc++) begin
            if (!aw_done && cyc >= aw_dly) S_AXI_AWVALID = 1'b1;
            if (!w_done && cyc >= w_dly)   S_AXI_WVALID  = 1'b1;
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge ACLK);
            @(negedge ACLK);
            if (aw_hs) begin S_AXI_AWVALID = 1'b0; aw_done = 1; end
            if (w_hs)  begin S_AXI_WVALID  = 1'b0; w_done  = 1; end
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        check("aw_w_accepted", {30'd0, aw_done, w_done}, 32'd3);
        for (cyc = 0; cyc < 16 && S_AXI_BVALID !== 1'b1; cyc++) @(negedge ACLK);
        check("bvalid_rise", {31'd0, S_AXI_BVALID}, 32'd1);
    endtask

    task automatic write_finish(input logic [1:0] exp_resp, input int b_dly);
        logic [1:0] r0 = S_AXI_BRESP;
        bit stable = 1;
        check("bresp", {30'd0, S_AXI_BRESP}, {30'd0, exp_resp});
        for (int i = 0; i < b_dly; i++) begin
            @(negedge ACLK);
            if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== r0 ||
                S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b0) stable = 0;
        end
        if (b_dly > 0) check("b_hold_stable", {31'd0, stable}, 32'd1);
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
        check("bvalid_drop", {31'd0, S_AXI_BVALID}, 32'd0);
        check("awready_after_b", {30'd0, S_AXI_AWREADY, S_AXI_WREADY}, 32'd3);
    endtask

    task automatic read_issue(input logic [4:0] addr);
        bit done = 0;
        bit hs;
        int cyc;
        S_AXI_ARADDR  = addr;
        S_AXI_RREADY  = 1'b0;
        S_AXI_ARVALID = 1'b1;
        for (cyc = 0; cyc < 32 && !done; cyc++) begin
            hs = S_AXI_ARREADY;
            @(posedge ACLK);
            @(negedge ACLK);
            if (hs) begin S_AXI_ARVALID = 1'b0; done = 1; end
        end
        S_AXI_ARVALID = 1'b0;
        check("ar_accepted", {31'd0, done}, 32'd1);
        check("rvalid_rise", {31'd0, S_AXI_RVALID}, 32'd1);
    endtask

    task automatic read_finish(input logic [31:0] exp_data, input logic [1:0] exp_resp, input int r_dly);
        logic [31:0] d0 = S_AXI_RDATA;
        logic [1:0]  r0 = S_AXI_RRESP;
        bit stable = 1;
        check("rdata", S_AXI_RDATA, exp_data);
        check("rresp", {30'd0, S_AXI_RRESP}, {30'd0, exp_resp});
        for (int i = 0; i < r_dly; i++) begin
            @(negedge ACLK);
            if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== d0 || S_AXI_RRESP !== r0 ||
                S_AXI_ARREADY !== 1'b0) stable = 0;
        end
        if (r_dly > 0) check("r_hold_stable", {31'd0, stable}, 32'd1);
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        S_AXI_RREADY = 1'b0;
        check("rvalid_drop", {31'd0, S_AXI_RVALID}, 32'd0);
    endtask

    task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
        int p0 = pulse_cnt;
        int exp_p = (addr[4:2] == 3'd0 && strb[0] && data[0]) ? 1 : 0;
        write_issue(addr, data, strb, aw_dly, w_dly);
        model_write(addr, data, strb);
        write_finish(exp_bresp(addr), b_dly);
        check("coef_update_count", pulse_cnt - p0, exp_p);
    endtask

    task automatic do_read(input logic [4:0] addr, input int r_dly);
        logic [31:0] ed;
        logic [1:0]  er;
        model_read(addr, ed, er);
        read_issue(addr);
        read_finish(ed, er, r_dly);
    endtask

    task automatic check_outputs_vs_model(input string tag);
        check({tag, "_ctrl"},    ctrl,    m_reg[0]);
        check({tag, "_coef_b0"}, coef_b0, m_reg[1]);
        check({tag, "_coef_b1"}, coef_b1, m_reg[2]);
        check({tag, "_coef_a1"}, coef_a1, m_reg[3]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready_valid"}, {26'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID,
                                      S_AXI_ARREADY, S_AXI_RVALID, coef_update}, 32'd0);
        check({tag, "_resp"},  {28'd0, S_AXI_BRESP, S_AXI_RRESP}, 32'd0);
        check({tag, "_rdata"}, S_AXI_RDATA, 32'd0);
        check({tag, "_regs"},  ctrl | coef_b0 | coef_b1 | coef_a1, 32'd0);
    endtask

    initial begin
        logic [4:0]  ra;
        logic [31:0] rd;
        logic [3:0]  rs;

        ARESETN = 1'b0;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0;  S_AXI_WSTRB = '0;  S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        status_val = 32'hCAFE0000;
        status_in  = status_val;
        for (int i = 0; i < 4; i++) m_reg[i] = 32'h0;

        repeat (3) @(negedge ACLK);
        check_all_zero("reset");
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);
        check("ready_after_reset", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd7);

        // Basic write/readback of the four R/W registers.
        do_write(5'h00, 32'h0101FFFF, 4'hF, 0, 0, 0);
        do_write(5'h04, 32'hABCD0001, 4'hF, 0, 0, 0);
        do_write(5'h08, 32'hDEAD0011, 4'hF, 0, 0, 0);
        do_write(5'h0C, 32'hBEEF0011, 4'hF, 0, 0, 0);
        do_read(5'h00, 0);
        do_read(5'h04, 0);
        do_read(5'h08, 0);
        do_read(5'h0C, 0);
        check_outputs_vs_model("basic");

        // W ahead of AW, then AW ahead of W.
        do_write(5'h04, 32'h11112222, 4'hF, 3, 0, 0);
        do_read(5'h04, 0);
        do_write(5'h04, 32'h33334444, 4'hF, 0, 3, 0);
        do_read(5'h04, 0);

        // Byte strobes, including an all-zero strobe.
        do_write(5'h08, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        do_write(5'h08, 32'h12345678, 4'b0101, 0, 0, 0);
        check("strobe_merge", coef_b1, 32'hFF34FF78);
        do_read(5'h08, 0);
        do_write(5'h0C, 32'h55555555, 4'h0, 0, 0, 0);
        check_outputs_vs_model("strobe");

        // Coefficient-update strobe.
        do_write(5'h00, 32'h00000001, 4'hF, 0, 0, 0);
        do_write(5'h00, 32'h00000000, 4'hF, 0, 0, 0);
        do_write(5'h00, 32'h00000001, 4'hF, 0, 0, 0);
        do_write(5'h00, 32'h00000001, 4'hF, 0, 0, 0);
        do_write(5'h00, 32'h00000001, 4'hE, 0, 0, 0);

        // Unmapped and read-only offsets.
        do_read(5'h14, 0);
        do_write(5'h18, 32'h87654321, 4'hF, 0, 0, 0);
        do_write(5'h10, 32'h87654321, 4'hF, 0, 0, 0);
        check_outputs_vs_model("unmapped");
        do_read(5'h10, 0);
        do_read(5'h1C, 0);

        // Back-pressure on both response channels.
        do_write(5'h0C, 32'h0BADF00D, 4'hF, 1, 2, 5);
        do_read(5'h0C, 5);

        // Random traffic against the model.
        for (int n = 0; n < 60; n++) begin
            status_val = $urandom;
            status_in  = status_val;
            repeat (2) @(negedge ACLK);
            ra = {3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 1) == 1) begin
                rd = $urandom;
                rs = 4'($urandom_range(0, 15));
                do_write(ra, rd, rs, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            end else begin
                do_read(ra, $urandom_range(0, 2));
            end
        end
        check_outputs_vs_model("random");

        // Reset while both responses are held pending.
        write_issue(5'h04, 32'hA5A5A5A5, 4'hF, 0, 0);
        model_write(5'h04, 32'hA5A5A5A5, 4'hF);
        read_issue(5'h00);
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b0;
        #1;
        check_all_zero("mid_reset");
        for (int i = 0; i < 4; i++) m_reg[i] = 32'h0;
        @(negedge ACLK);
        ARESETN = 1'b1;
        S_AXI_BREADY = 1'b1;
        S_AXI_RREADY = 1'b1;
        repeat (4) @(negedge ACLK);
        check("no_resp_after_reset", {30'd0, S_AXI_BVALID, S_AXI_RVALID}, 32'd0);
        S_AXI_BREADY = 1'b0;
        S_AXI_RREADY = 1'b0;
        do_read(5'h04, 0);
        check_outputs_vs_model("post_reset");

        check("coef_update_shape", pulse_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
